// File: rtl/sequenziatore_partita.sv
// Game sequencer in front of the match datapath: collects one move per player,
// issues setup/count pulses, samples the datapath result and tracks the game.
module sequenziatore_partita #(
   parameter int unsigned DP_LAT  = 1,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       NUOVA,
   input  logic [3:0] CFG,
   input  logic       P1_VALID,
   input  logic [1:0] P1_MOSSA,
   output logic       P1_ACK,
   input  logic       P2_VALID,
   input  logic [1:0] P2_MOSSA,
   output logic       P2_ACK,
   output logic       INIZIO_SETUP,
   output logic       INIZIO_CONTO,
   output logic [1:0] PRIMO,
   output logic [1:0] SECONDO,
   input  logic [1:0] MANCHE,
   input  logic [1:0] PARTITA,
   output logic [1:0] ESITO_MANCHE,
   output logic       ESITO_VALID,
   output logic [4:0] N_MANCHE,
   output logic       TIMEOUT_ERR,
   output logic       FINE,
   output logic [1:0] VINCITORE
);

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned LAT_W    = 2;
   localparam int unsigned NM_W     = 5;
   localparam int unsigned TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam int unsigned LAT_LAST = (DP_LAT > 1) ? DP_LAT - 2 : 0;
   localparam logic [NM_W-1:0] NM_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ATTESA, S_CONTO, S_LATENZA, S_VERIFICA, S_FINE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cfg;
   logic [1:0]        r_slot1, r_slot2;
   logic              r_full1, r_full2;
   logic [CNT_W-1:0]  r_cnt;
   logic [LAT_W-1:0]  r_lat;
   logic              r_p1_ack, r_p2_ack, r_err, r_esito_valid;
   logic [1:0]        r_esito, r_vinc;
   logic [NM_W-1:0]   r_n;

   logic w_new, w_attesa, w_take1, w_take2, w_one, w_expire, w_count, w_verif;

   // A new game request is honoured everywhere except in SETUP; it pre-empts any other action
   assign w_new    = NUOVA && (r_state != S_SETUP);
   assign w_attesa = (r_state == S_ATTESA) && !NUOVA;
   assign w_take1  = w_attesa && P1_VALID && !r_full1;
   assign w_take2  = w_attesa && P2_VALID && !r_full2;
   assign w_one    = r_full1 ^ r_full2;
   // Expiry on the last waiting cycle, unless the missing move arrives in that same cycle
   assign w_expire = (TIMEOUT != 0) && w_attesa && w_one && (r_cnt == CNT_W'(TO_LAST))
                     && !(w_take1 || w_take2);
   assign w_count  = (TIMEOUT != 0) && w_attesa && w_one && !w_expire;
   assign w_verif  = (r_state == S_VERIFICA) && !NUOVA;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      if (w_new) begin
         w_next = S_SETUP;
      end else begin
         case (r_state)
            S_SETUP:    w_next = S_ATTESA;
            S_ATTESA:   if (r_full1 && r_full2) w_next = S_CONTO;
            S_CONTO:    w_next = (DP_LAT > 1) ? S_LATENZA : S_VERIFICA;
            S_LATENZA:  if (r_lat == LAT_W'(LAT_LAST)) w_next = S_VERIFICA;
            S_VERIFICA: w_next = (PARTITA != 2'b00) ? S_FINE : S_ATTESA;
            default:    w_next = r_state;
         endcase
      end
   end

   // Moore decode of the datapath controls and the game-over flag
   always_comb begin
      INIZIO_SETUP = 1'b0;
      INIZIO_CONTO = 1'b0;
      PRIMO        = 2'b00;
      SECONDO      = 2'b00;
      FINE         = 1'b0;
      case (r_state)
         S_SETUP: begin
            INIZIO_SETUP = 1'b1;
            PRIMO        = r_cfg[1:0];
            SECONDO      = r_cfg[3:2];
         end
         S_CONTO: begin
            INIZIO_CONTO = 1'b1;
            PRIMO        = r_slot1;
            SECONDO      = r_slot2;
         end
         S_FINE:  FINE = 1'b1;
         default: ;
      endcase
   end

   // Handshake pulses, move slots, timeout/latency counters and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg         <= 4'b0000;
         r_slot1       <= 2'b00;
         r_slot2       <= 2'b00;
         r_full1       <= 1'b0;
         r_full2       <= 1'b0;
         r_cnt         <= '0;
         r_lat         <= '0;
         r_p1_ack      <= 1'b0;
         r_p2_ack      <= 1'b0;
         r_err         <= 1'b0;
         r_esito_valid <= 1'b0;
         r_esito       <= 2'b00;
         r_vinc        <= 2'b00;
         r_n           <= '0;
      end else begin
         r_p1_ack      <= w_take1;
         r_p2_ack      <= w_take2;
         r_err         <= w_expire;
         r_esito_valid <= w_verif;
         if (w_new) r_cfg <= CFG;

         if ((r_state == S_SETUP) || w_verif) begin
            r_full1 <= 1'b0;
            r_full2 <= 1'b0;
         end else begin
            if (w_take1) begin
               r_full1 <= 1'b1;
               r_slot1 <= P1_MOSSA;
            end else if (w_expire) begin
               r_full1 <= 1'b0;
            end
            if (w_take2) begin
               r_full2 <= 1'b1;
               r_slot2 <= P2_MOSSA;
            end else if (w_expire) begin
               r_full2 <= 1'b0;
            end
         end

         r_cnt <= w_count ? r_cnt + CNT_W'(1) : '0;
         r_lat <= (r_state == S_LATENZA) ? r_lat + LAT_W'(1) : '0;

         if (r_state == S_SETUP) begin
            r_esito <= 2'b00;
            r_vinc  <= 2'b00;
            r_n     <= '0;
         end else if (w_verif) begin
            r_esito <= MANCHE;
            if ((MANCHE != 2'b00) && (r_n != NM_MAX)) r_n <= r_n + NM_W'(1);
            if (PARTITA != 2'b00) r_vinc <= PARTITA;
         end
      end
   end

   assign P1_ACK       = r_p1_ack;
   assign P2_ACK       = r_p2_ack;
   assign TIMEOUT_ERR  = r_err;
   assign ESITO_VALID  = r_esito_valid;
   assign ESITO_MANCHE = r_esito;
   assign N_MANCHE     = r_n;
   assign VINCITORE    = r_vinc;

endmodule

// File: tb/tb_sequenziatore_partita.sv
// Scoreboard bench for sequenziatore_partita: stimulus pushes expected events
// (with their expected cycle), a negedge monitor pops and compares them.
module tb_sequenziatore_partita;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       NUOVA = 1'b0;
   logic [3:0] CFG = 4'b0000;
   logic       P1_VALID = 1'b0, P2_VALID = 1'b0;
   logic [1:0] P1_MOSSA = 2'b00, P2_MOSSA = 2'b00;
   logic       P1_ACK, P2_ACK, INIZIO_SETUP, INIZIO_CONTO, ESITO_VALID, TIMEOUT_ERR, FINE;
   logic [1:0] PRIMO, SECONDO, ESITO_MANCHE, VINCITORE;
   logic [1:0] MANCHE = 2'b00, PARTITA = 2'b00;
   logic [4:0] N_MANCHE;

   sequenziatore_partita #(.DP_LAT(1), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .NUOVA(NUOVA), .CFG(CFG),
      .P1_VALID(P1_VALID), .P1_MOSSA(P1_MOSSA), .P1_ACK(P1_ACK),
      .P2_VALID(P2_VALID), .P2_MOSSA(P2_MOSSA), .P2_ACK(P2_ACK),
      .INIZIO_SETUP(INIZIO_SETUP), .INIZIO_CONTO(INIZIO_CONTO),
      .PRIMO(PRIMO), .SECONDO(SECONDO), .MANCHE(MANCHE), .PARTITA(PARTITA),
      .ESITO_MANCHE(ESITO_MANCHE), .ESITO_VALID(ESITO_VALID), .N_MANCHE(N_MANCHE),
      .TIMEOUT_ERR(TIMEOUT_ERR), .FINE(FINE), .VINCITORE(VINCITORE)
   );

   typedef struct {
      int         cyc;
      logic [1:0] x;
      logic [1:0] y;
      logic [4:0] n;
      logic       fine;
      logic [1:0] vinc;
   } ev_t;

   ev_t q_ack1[$], q_ack2[$], q_err[$], q_conto[$], q_esito[$], q_setup[$];

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int ack_pulses = 0;
   int n_model = 0;
   bit game_over = 1'b1;
   logic [1:0] prog_m = 2'b00, prog_p = 2'b00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath stub: result appears one cycle after the count pulse, zero otherwise
   always @(posedge clk) begin
      if (INIZIO_CONTO) begin
         MANCHE  <= prog_m;
         PARTITA <= prog_p;
      end else begin
         MANCHE  <= 2'b00;
         PARTITA <= 2'b00;
      end
   end

   function automatic ev_t mk_ev(input int c, input logic [1:0] x, input logic [1:0] y,
                                 input logic [4:0] n, input logic f, input logic [1:0] v);
      ev_t e;
      e.cyc = c; e.x = x; e.y = y; e.n = n; e.fine = f; e.vinc = v;
      return e;
   endfunction

   function automatic int outs();
      return int'({P1_ACK, P2_ACK, INIZIO_SETUP, INIZIO_CONTO, PRIMO, SECONDO, ESITO_MANCHE,
                   ESITO_VALID, N_MANCHE, TIMEOUT_ERR, FINE, VINCITORE});
   endfunction

   function automatic int pending();
      return q_ack1.size() + q_ack2.size() + q_err.size() + q_conto.size()
           + q_esito.size() + q_setup.size();
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pop the expected event of one kind and compare it with what the DUT shows now
   task automatic observe(input int kind, input string name);
      ev_t e;
      int  sz;
      case (kind)
         0: sz = q_ack1.size();
         1: sz = q_ack2.size();
         2: sz = q_err.size();
         3: sz = q_conto.size();
         4: sz = q_esito.size();
         default: sz = q_setup.size();
      endcase
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: pulse seen at cycle %0d, expected none", name, cyc);
         return;
      end
      case (kind)
         0: e = q_ack1.pop_front();
         1: e = q_ack2.pop_front();
         2: e = q_err.pop_front();
         3: e = q_conto.pop_front();
         4: e = q_esito.pop_front();
         default: e = q_setup.pop_front();
      endcase
      chk({name, " cycle"}, cyc, e.cyc);
      if (kind == 3 || kind == 5) begin
         chk({name, " PRIMO"}, int'(PRIMO), int'(e.x));
         chk({name, " SECONDO"}, int'(SECONDO), int'(e.y));
      end
      if (kind == 4) begin
         chk({name, " ESITO_MANCHE"}, int'(ESITO_MANCHE), int'(e.x));
         chk({name, " N_MANCHE"}, int'(N_MANCHE), int'(e.n));
         chk({name, " FINE"}, int'(FINE), int'(e.fine));
         chk({name, " VINCITORE"}, int'(VINCITORE), int'(e.vinc));
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (cyc >= 1) begin
         ack_pulses += int'(P1_ACK) + int'(P2_ACK);
         if (P1_ACK)       observe(0, "ack1");
         if (P2_ACK)       observe(1, "ack2");
         if (TIMEOUT_ERR)  observe(2, "timeout_err");
         if (INIZIO_CONTO) observe(3, "conto");
         if (ESITO_VALID)  observe(4, "esito");
         if (INIZIO_SETUP) observe(5, "setup");
         if (!INIZIO_SETUP && !INIZIO_CONTO)
            chk("idle PRIMO/SECONDO", int'({PRIMO, SECONDO}), 0);
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: still running at cycle %0d, expected to finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; NUOVA = 1'b0; P1_VALID = 1'b0; P2_VALID = 1'b0;
      @(negedge clk);
      chk("reset outputs", outs(), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle outputs", outs(), 0);
   endtask

   // Called right after a negedge; returns two cycles later in ATTESA
   task automatic new_game(input logic [3:0] cfg);
      q_setup.push_back(mk_ev(cyc + 1, cfg[1:0], cfg[3:2], 5'd0, 1'b0, 2'b00));
      NUOVA = 1'b1;
      CFG   = cfg;
      @(negedge clk);
      NUOVA = 1'b0;
      @(negedge clk);
      chk("post-setup outputs", outs(), 0);
      chk("setup seen", q_setup.size(), 0);
      n_model   = 0;
      game_over = 1'b0;
   endtask

   // One round: first player raises now, the other g cycles later
   task automatic run_round(input bit p2_first, input int g, input logic [1:0] m1,
                            input logic [1:0] m2, input logic [1:0] manche,
                            input logic [1:0] partita);
      int k;
      bit done;
      ev_t a_first, a_second;
      k = cyc;
      prog_m = manche;
      prog_p = partita;
      a_first  = mk_ev(k + 1, 2'b00, 2'b00, 5'd0, 1'b0, 2'b00);
      a_second = mk_ev(k + g + 1, 2'b00, 2'b00, 5'd0, 1'b0, 2'b00);
      if (p2_first) begin
         q_ack2.push_back(a_first);
         q_ack1.push_back(a_second);
      end else begin
         q_ack1.push_back(a_first);
         q_ack2.push_back(a_second);
      end
      if (g <= TO) begin
         q_conto.push_back(mk_ev(k + g + 2, m1, m2, 5'd0, 1'b0, 2'b00));
         if (manche != 2'b00 && n_model < 31) n_model++;
         q_esito.push_back(mk_ev(k + g + 4, manche, 2'b00, 5'(n_model),
                                 partita != 2'b00, partita));
         game_over = (partita != 2'b00);
      end else begin
         q_err.push_back(mk_ev(k + 1 + TO, 2'b00, 2'b00, 5'd0, 1'b0, 2'b00));
         q_err.push_back(mk_ev(k + g + 1 + TO, 2'b00, 2'b00, 5'd0, 1'b0, 2'b00));
      end
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         if (t == 0 || t == g) begin
            if ((t == 0) != p2_first || (t == 0 && g == 0)) begin
               P1_VALID = 1'b1; P1_MOSSA = m1;
            end
            if ((t == 0) == p2_first || (t == 0 && g == 0)) begin
               P2_VALID = 1'b1; P2_MOSSA = m2;
            end
         end
         @(negedge clk);
         if (P1_ACK) P1_VALID = 1'b0;
         if (P2_ACK) P2_VALID = 1'b0;
         if (t >= g && !P1_VALID && !P2_VALID && pending() == 0) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL round budget: %0d events still pending at cycle %0d, expected 0", pending(), cyc);
         q_ack1.delete(); q_ack2.delete(); q_err.delete();
         q_conto.delete(); q_esito.delete(); q_setup.delete();
         P1_VALID = 1'b0; P2_VALID = 1'b0;
      end
   endtask

   initial begin
      int k;
      int ack0;
      int g;
      logic [1:0] mn, pt;

      // Reset and first setup
      do_reset();
      new_game(4'b0110);

      // Staggered round, simultaneous invalid round, timeout and accept-on-expiry
      run_round(1'b0, 3, 2'b01, 2'b10, 2'b10, 2'b00);
      chk("N_MANCHE after first round", int'(N_MANCHE), 1);
      run_round(1'b0, 0, 2'b11, 2'b00, 2'b00, 2'b00);
      chk("N_MANCHE after invalid round", int'(N_MANCHE), 1);
      run_round(1'b0, TO + 1, 2'b01, 2'b01, 2'b01, 2'b00);
      run_round(1'b1, TO, 2'b10, 2'b11, 2'b01, 2'b00);

      // Game end, then moves ignored while finished
      run_round(1'b1, 2, 2'b00, 2'b01, 2'b11, 2'b01);
      chk("FINE after game end", int'(FINE), 1);
      chk("VINCITORE after game end", int'(VINCITORE), 1);
      ack0 = ack_pulses;
      P1_VALID = 1'b1; P2_VALID = 1'b1;
      repeat (6) @(negedge clk);
      chk("acks while finished", ack_pulses, ack0);
      chk("FINE held", int'(FINE), 1);
      chk("VINCITORE held", int'(VINCITORE), 1);
      P1_VALID = 1'b0; P2_VALID = 1'b0;
      @(negedge clk);
      new_game(4'b1001);

      // Abort: new game requested in the count cycle
      k = cyc;
      prog_m = 2'b11; prog_p = 2'b01;
      q_ack1.push_back(mk_ev(k + 1, 2'b00, 2'b00, 5'd0, 1'b0, 2'b00));
      q_ack2.push_back(mk_ev(k + 1, 2'b00, 2'b00, 5'd0, 1'b0, 2'b00));
      q_conto.push_back(mk_ev(k + 2, 2'b10, 2'b01, 5'd0, 1'b0, 2'b00));
      P1_VALID = 1'b1; P1_MOSSA = 2'b10; P2_VALID = 1'b1; P2_MOSSA = 2'b01;
      @(negedge clk);
      P1_VALID = 1'b0; P2_VALID = 1'b0;
      @(negedge clk);
      new_game(4'b0011);
      chk("FINE after abort", int'(FINE), 0);

      // Reset with one buffered move
      k = cyc;
      q_ack1.push_back(mk_ev(k + 1, 2'b00, 2'b00, 5'd0, 1'b0, 2'b00));
      P1_VALID = 1'b1; P1_MOSSA = 2'b11;
      @(negedge clk);
      P1_VALID = 1'b0;
      P2_VALID = 1'b1; P2_MOSSA = 2'b10;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid-round reset outputs", outs(), 0);
      ack0 = ack_pulses;
      repeat (TO + 4) @(negedge clk);
      chk("acks in idle", ack_pulses, ack0);
      chk("idle outputs after reset", outs(), 0);
      P2_VALID = 1'b0;
      @(negedge clk);

      // Randomized games; the first one runs long enough to saturate the round count
      for (int gm = 0; gm < 4; gm++) begin
         new_game(4'($urandom));
         for (int r = 0; r < 46 && !game_over; r++) begin
            g  = (gm == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, TO + 2));
            mn = (gm == 0) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            pt = 2'b00;
            if ((gm == 0) ? (r == 45) : ($urandom_range(0, 4) == 0)) pt = 2'($urandom_range(1, 3));
            run_round(1'($urandom_range(0, 1)), g, 2'($urandom), 2'($urandom), mn, pt);
         end
         if (gm == 0) chk("N_MANCHE saturated", int'(N_MANCHE), 31);
      end

      repeat (3) @(negedge clk);
      chk("events left over", pending(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
